// File: rtl/gat_pkg.sv
// Shared definitions for the GAT attention datapath: default sizes and packer states.
package gat_pkg;

    localparam int unsigned GAT_DATA_WIDTH   = 8;
    localparam int unsigned GAT_NUM_OF_NODES = 5;

    typedef enum logic {
        Collect = 1'b0,
        Send    = 1'b1
    } pack_state_e;

endpackage

// File: rtl/coef_packer.sv
// Packs a serial stream of signed attention coefficients into one flat vector for softmax,
// first neighbour in the MSB slice, unused slots filled with PAD_VALUE.
module coef_packer
    import gat_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = GAT_DATA_WIDTH,
    parameter int unsigned NUM_OF_NODES = GAT_NUM_OF_NODES,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = {1'b1, {(DATA_WIDTH-1){1'b0}}},
    localparam int unsigned DATA_WIDTH_FLAT = NUM_OF_NODES * DATA_WIDTH,
    localparam int unsigned CNT_WIDTH       = $clog2(NUM_OF_NODES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coef_valid_i,
    output logic                       coef_ready_o,
    input  logic [DATA_WIDTH-1:0]      coef_data_i,
    input  logic                       coef_last_i,
    output logic                       sm_valid_o,
    input  logic                       sm_ready_i,
    output logic [DATA_WIDTH_FLAT-1:0] coef_o,
    output logic [CNT_WIDTH-1:0]       cnt_o
);

    pack_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 beat_acc;
    logic                 vec_acc;
    logic                 close_pkt;

    // rst_n is active high here; ready is held low while it is asserted.
    assign coef_ready_o = (state_q == Collect) && !rst_n;
    assign sm_valid_o   = (state_q == Send);
    assign beat_acc     = coef_valid_i && coef_ready_o;
    assign vec_acc      = sm_valid_o && sm_ready_i;
    assign close_pkt    = coef_last_i || (idx_q == CNT_WIDTH'(NUM_OF_NODES - 1));
    assign cnt_o        = cnt_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= Collect;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            Collect: begin
                if (beat_acc) begin
                    if (close_pkt) begin
                        state_d = Send;
                        idx_d   = '0;
                        cnt_d   = idx_q + CNT_WIDTH'(1);
                    end else begin
                        idx_d = idx_q + CNT_WIDTH'(1);
                    end
                end
            end
            Send: begin
                if (vec_acc) begin
                    state_d = Collect;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = Collect;
        endcase
    end

    // Slots start every packet at PAD_VALUE, so closing early needs no explicit fill.
    for (genvar k = 0; k < NUM_OF_NODES; k++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_q;

        always_ff @(posedge clk) begin
            if (rst_n || vec_acc) begin
                slot_q <= PAD_VALUE;
            end else if (beat_acc && (idx_q == CNT_WIDTH'(k))) begin
                slot_q <= coef_data_i;
            end
        end

        assign coef_o[DATA_WIDTH*(NUM_OF_NODES-k)-1 -: DATA_WIDTH] = slot_q;
    end

endmodule

// File: tb/tb_coef_packer.sv
// Directed bench for coef_packer with default parameters (8-bit slots, 5 nodes).
module tb_coef_packer;

    logic        clk;
    logic        rst_n;
    logic        coef_valid_i;
    logic        coef_ready_o;
    logic [7:0]  coef_data_i;
    logic        coef_last_i;
    logic        sm_valid_o;
    logic        sm_ready_i;
    logic [39:0] coef_o;
    logic [2:0]  cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [39:0] AllPad = 40'h8080808080;

    coef_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coef_valid_i (coef_valid_i),
        .coef_ready_o (coef_ready_o),
        .coef_data_i  (coef_data_i),
        .coef_last_i  (coef_last_i),
        .sm_valid_o   (sm_valid_o),
        .sm_ready_i   (sm_ready_i),
        .coef_o       (coef_o),
        .cnt_o        (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic beat(input logic [7:0] data, input logic last);
        coef_valid_i = 1'b1;
        coef_data_i  = data;
        coef_last_i  = last;
        tick();
        coef_valid_i = 1'b0;
        coef_last_i  = 1'b0;
    endtask

    task automatic handshake();
        sm_ready_i = 1'b1;
        tick();
        sm_ready_i = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b1;
        coef_valid_i = 1'b0;
        coef_data_i  = '0;
        coef_last_i  = 1'b0;
        sm_ready_i   = 1'b0;

        // Reset state
        tick();
        sample();
        check("rst_ready", coef_ready_o, 1'b0);
        check("rst_valid", sm_valid_o, 1'b0);
        check("rst_coef", coef_o, AllPad);
        check("rst_cnt", cnt_o, 3'd0);
        tick();
        rst_n = 1'b0;
        sample();
        check("post_rst_ready", coef_ready_o, 1'b1);

        // Full packet
        tick();
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        sample();
        check("full_not_yet", sm_valid_o, 1'b0);
        tick();
        beat(8'h05, 1'b1);
        sample();
        check("full_valid", sm_valid_o, 1'b1);
        check("full_coef", coef_o, 40'h0102030405);
        check("full_cnt", cnt_o, 3'd5);
        check("full_ready", coef_ready_o, 1'b0);
        tick();
        handshake();
        sample();
        check("hs_valid", sm_valid_o, 1'b0);
        check("hs_ready", coef_ready_o, 1'b1);
        check("hs_pad", coef_o, AllPad);

        // Short packet with backpressure and an ignored serial beat
        tick();
        beat(8'h7f, 1'b0);
        beat(8'h10, 1'b1);
        sample();
        check("short_coef", coef_o, 40'h7f10808080);
        check("short_cnt", cnt_o, 3'd2);
        tick();
        coef_valid_i = 1'b1;
        coef_data_i  = 8'h55;
        coef_last_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("bp_valid", sm_valid_o, 1'b1);
            check("bp_ready", coef_ready_o, 1'b0);
            check("bp_coef", coef_o, 40'h7f10808080);
            check("bp_cnt", cnt_o, 3'd2);
            tick();
        end
        coef_valid_i = 1'b0;
        coef_last_i  = 1'b0;
        handshake();
        sample();
        check("bp_release_valid", sm_valid_o, 1'b0);
        check("bp_release_ready", coef_ready_o, 1'b1);
        check("bp_no_leak", coef_o, AllPad);

        // sm_ready_i while idle does nothing
        tick();
        sm_ready_i = 1'b1;
        tick();
        sm_ready_i = 1'b0;
        sample();
        check("idle_ready_valid", sm_valid_o, 1'b0);
        check("idle_ready_coef", coef_o, AllPad);

        // Overrun: closes on the fifth beat without last
        tick();
        beat(8'h11, 1'b0);
        beat(8'h12, 1'b0);
        beat(8'h13, 1'b0);
        beat(8'h14, 1'b0);
        beat(8'h15, 1'b0);
        sample();
        check("ovr_valid", sm_valid_o, 1'b1);
        check("ovr_coef", coef_o, 40'h1112131415);
        check("ovr_cnt", cnt_o, 3'd5);
        tick();
        handshake();
        beat(8'h21, 1'b1);
        sample();
        check("ovr_next_coef", coef_o, 40'h2180808080);
        check("ovr_next_cnt", cnt_o, 3'd1);
        tick();
        handshake();

        // Reset mid-packet discards the partial data
        beat(8'h31, 1'b0);
        beat(8'h32, 1'b0);
        beat(8'h33, 1'b0);
        rst_n = 1'b1;
        sample();
        check("midrst_ready", coef_ready_o, 1'b0);
        tick();
        rst_n = 1'b0;
        sample();
        check("midrst_valid", sm_valid_o, 1'b0);
        check("midrst_coef", coef_o, AllPad);
        check("midrst_cnt", cnt_o, 3'd0);
        tick();
        sample();
        check("midrst_still_idle", sm_valid_o, 1'b0);
        tick();
        beat(8'h0a, 1'b1);
        sample();
        check("midrst_next_coef", coef_o, 40'h0a80808080);
        check("midrst_next_cnt", cnt_o, 3'd1);
        tick();
        handshake();

        // Back-to-back single-beat packets: one bubble between acceptances
        sm_ready_i   = 1'b1;
        coef_valid_i = 1'b1;
        coef_last_i  = 1'b1;
        coef_data_i  = 8'h41;
        sample();
        check("b2b_acc0", coef_ready_o, 1'b1);
        tick();
        coef_data_i = 8'h42;
        sample();
        check("b2b_bubble", coef_ready_o, 1'b0);
        check("b2b_vec0_valid", sm_valid_o, 1'b1);
        check("b2b_vec0_coef", coef_o, 40'h4180808080);
        check("b2b_vec0_cnt", cnt_o, 3'd1);
        tick();
        sample();
        check("b2b_acc1", coef_ready_o, 1'b1);
        check("b2b_gap_valid", sm_valid_o, 1'b0);
        tick();
        coef_valid_i = 1'b0;
        coef_last_i  = 1'b0;
        sample();
        check("b2b_vec1_valid", sm_valid_o, 1'b1);
        check("b2b_vec1_coef", coef_o, 40'h4280808080);
        check("b2b_vec1_cnt", cnt_o, 3'd1);
        tick();
        sample();
        check("b2b_done_valid", sm_valid_o, 1'b0);
        sm_ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/coef_packer.md
COEF_PACKER -- requirements
Module: coef_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one signed attention coefficient.
REQ-002 Parameter NUM_OF_NODES, default 5, coefficient slots per packed vector.
REQ-003 Parameter PAD_VALUE, default 8'h80 (most-negative signed), fill for unused slots.
REQ-004 Local DATA_WIDTH_FLAT = NUM_OF_NODES*DATA_WIDTH; CNT_WIDTH = $clog2(NUM_OF_NODES+1).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-high reset (reset asserted when rst_n = 1).
REQ-007 coef_valid_i  input  1  serial coefficient valid.
REQ-008 coef_ready_o  output  1  packer accepts serial coefficient.
REQ-009 coef_data_i  input  DATA_WIDTH  serial coefficient, one neighbour per beat.
REQ-010 coef_last_i  input  1  marks final coefficient of current node's neighbour list.
REQ-011 sm_valid_o  output  1  packed vector valid toward softmax.
REQ-012 sm_ready_i  input  1  softmax accepts packed vector.
REQ-013 coef_o  output  DATA_WIDTH_FLAT  packed coefficient vector.
REQ-014 cnt_o  output  CNT_WIDTH  number of real (non-pad) slots in coef_o, 1..NUM_OF_NODES.

Function
REQ-015 States SHALL be COLLECT and SEND; reset state COLLECT.
REQ-016 coef_ready_o SHALL equal 1 in COLLECT and 0 in SEND (registered-state decode, no dependency on sm_ready_i).
REQ-017 A serial beat is accepted when coef_valid_i & coef_ready_o; only accepted beats change state.
REQ-018 The k-th accepted beat of a packet (k = 0..NUM_OF_NODES-1) SHALL be written to slice coef_o[DATA_WIDTH*(NUM_OF_NODES-k)-1 : DATA_WIDTH*(NUM_OF_NODES-1-k)], i.e. first neighbour in MSB slice, matching softmax de-flatten order.
REQ-019 A packet closes on an accepted beat with coef_last_i = 1, or on the NUM_OF_NODES-th accepted beat regardless of coef_last_i.
REQ-020 On close, slots k+1..NUM_OF_NODES-1 SHALL hold PAD_VALUE, cnt_o SHALL equal k+1, and state moves to SEND.
REQ-021 sm_valid_o SHALL rise the cycle after the closing beat is accepted (latency 1 from closing beat).
REQ-022 In SEND, coef_o and cnt_o SHALL stay stable while sm_valid_o = 1 and sm_ready_i = 0.
REQ-023 On sm_valid_o & sm_ready_i, next cycle: sm_valid_o = 0, state COLLECT, write index 0, all slots reloaded with PAD_VALUE.
REQ-024 sm_ready_i asserted while sm_valid_o = 0 SHALL have no effect.
REQ-025 Write index counter SHALL never exceed NUM_OF_NODES-1; no wrap within a packet.
REQ-026 Back-to-back: a new packet's first beat may be accepted the cycle after the vector handshake (one bubble per packet).
REQ-027 Arithmetic: data passes unmodified; no sign extension, saturation or reordering of bits within a slice.

Reset
REQ-028 On reset: state COLLECT, write index 0, sm_valid_o = 0, coef_ready_o = 1 after reset deasserts, coef_o = all slots PAD_VALUE, cnt_o = 0.
REQ-029 Reset mid-packet or mid-SEND SHALL discard partial/pending data; no vector emitted for it.
REQ-030 During reset coef_ready_o SHALL be 0.

Structure
REQ-031 Shared package gat_pkg SHALL hold DATA_WIDTH, NUM_OF_NODES defaults and the COLLECT/SEND state encoding.
REQ-032 Single module, no sub-modules; slot registers built with generate loop over NUM_OF_NODES.

Verification
REQ-033 Full packet: beats 01,02,03,04,05, last on 05 -> coef_o = 0x0102030405, cnt_o = 5, sm_valid_o one cycle after beat 05.
REQ-034 Short packet: beats 7F,10, last on 10 -> coef_o = 0x7F10808080, cnt_o = 2.
REQ-035 Backpressure: sm_ready_i = 0 for 4 cycles after sm_valid_o -> coef_o, cnt_o stable, coef_ready_o = 0, coef_valid_i ignored; handshake on cycle 5 -> COLLECT next cycle.
REQ-036 Overrun: 5 beats with coef_last_i = 0 -> packet closes at 5th beat, cnt_o = 5; next beat starts new packet in slot 0.
REQ-037 Reset mid-packet after 3 beats -> sm_valid_o stays 0, coef_o = 0x8080808080, cnt_o = 0; next packet 0A last -> 0x0A80808080, cnt_o = 1.
REQ-038 Back-to-back: two single-beat packets with coef_valid_i held high and sm_ready_i = 1 -> exactly one bubble cycle between acceptances, both vectors correct.
